axil_pwm_slave: RTL and testbench

AXIL_PWM_SLAVE -- requirements
Module: axil_pwm_slave

---
 rtl/axil_pwm_pkg.sv | 33 +++
 rtl/axil_pwm_if.sv | 37 +++
 rtl/pwm_core.sv | 45 ++++
 rtl/axil_pwm_slave.sv | 105 ++++++++++
 tb/tb_axil_pwm_slave.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pwm_pkg.sv
// Shared constants for the AXI4-Lite PWM slave: register offsets, response codes, CTRL bits.
package axil_pwm_pkg;

  typedef enum logic [1:0] {
    RegCtrl    = 2'd0,
    RegPeriod  = 2'd1,
    RegDuty    = 2'd2,
    RegScratch = 2'd3
  } reg_idx_e;

  localparam logic [3:0] OFS_CTRL    = 4'h0;
  localparam logic [3:0] OFS_PERIOD  = 4'h4;
  localparam logic [3:0] OFS_DUTY    = 4'h8;
  localparam logic [3:0] OFS_SCRATCH = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_EN_BIT = 0;

  // Byte-lane merge of a write into an existing 32-bit register.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_pwm_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_pwm_if #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [AddrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/pwm_core.sv
// PWM counter with shadowed period/duty that only change at period boundaries or on enable.
module pwm_core #(
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] period_i,
    input  logic [CntWidth-1:0] duty_i,
    output logic                pwm_o
);
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] period_s_q, period_s_d;
    logic [CntWidth-1:0] duty_s_q, duty_s_d;
    logic                en_q;
    logic                pwm_q, pwm_d;
    logic                load;

    always_comb begin
        // Reload on enable rise, at the last count of a period, or every cycle while period is 0.
        load = en_i && (!en_q || (period_s_q == '0) || (cnt_q == period_s_q - CntWidth'(1)));
        period_s_d = load ? period_i : period_s_q;
        duty_s_d   = load ? duty_i : duty_s_q;
        cnt_d      = (!en_i || load) ? '0 : cnt_q + CntWidth'(1);
        pwm_d      = en_i && en_q && (period_s_q != '0) && (cnt_q < duty_s_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            period_s_q <= '0;
            duty_s_q   <= '0;
            en_q       <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            en_q       <= en_i;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/axil_pwm_slave.sv
// AXI4-Lite register front-end (CTRL/PERIOD/DUTY/SCRATCH) driving a single pwm_core.
module axil_pwm_slave
    import axil_pwm_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_CNT_WIDTH        = 32
) (
    input  logic       ACLK,
    input  logic       ARESET,
    axil_pwm_if.slave  s_axi,
    output logic       PWM_OUT
);
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];
    logic                          aw_ready_q, aw_ready_d;
    logic                          b_valid_q, b_valid_d;
    logic [1:0]                    b_resp_q, b_resp_d;
    logic                          ar_ready_q, ar_ready_d;
    logic [1:0]                    ar_idx_q, ar_idx_d;
    logic                          r_valid_q, r_valid_d;
    logic [1:0]                    r_resp_q, r_resp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                          wr_en, rd_en;
    logic                          unused_inputs;

    assign wr_en = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_en = ar_ready_q && s_axi.arvalid;

    always_comb begin
        regs_d     = regs_q;
        aw_ready_d = !aw_ready_q && s_axi.awvalid && s_axi.wvalid && !b_valid_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        ar_ready_d = !ar_ready_q && s_axi.arvalid && !r_valid_q;
        ar_idx_d   = ar_ready_d ? s_axi.araddr[3:2] : ar_idx_q;
        r_valid_d  = r_valid_q;
        r_resp_d   = r_resp_q;
        r_data_d   = r_data_q;

        if (wr_en) begin
            regs_d[s_axi.awaddr[3:2]] = apply_wstrb(regs_q[s_axi.awaddr[3:2]], s_axi.wdata,
                                                    s_axi.wstrb);
            b_valid_d = 1'b1;
            b_resp_d  = RESP_OKAY;
        end else if (s_axi.bready) begin
            b_valid_d = 1'b0;
        end

        // regs_q is the pre-write value, so a same-edge read sees the old contents.
        if (rd_en) begin
            r_valid_d = 1'b1;
            r_resp_d  = RESP_OKAY;
            r_data_d  = regs_q[ar_idx_q];
        end else if (s_axi.rready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            ar_ready_q <= 1'b0;
            ar_idx_q   <= 2'd0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= 2'b00;
            r_data_q   <= '0;
        end else begin
            regs_q     <= regs_d;
            aw_ready_q <= aw_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            ar_ready_q <= ar_ready_d;
            ar_idx_q   <= ar_idx_d;
            r_valid_q  <= r_valid_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
        end
    end

    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = aw_ready_q;
    assign s_axi.bvalid  = b_valid_q;
    assign s_axi.bresp   = b_resp_q;
    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = r_valid_q;
    assign s_axi.rresp   = r_resp_q;
    assign s_axi.rdata   = r_data_q;

    assign unused_inputs = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    pwm_core #(
        .CntWidth (C_CNT_WIDTH)
    ) u_pwm_core (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .en_i     (regs_q[RegCtrl][CTRL_EN_BIT]),
        .period_i (regs_q[RegPeriod][C_CNT_WIDTH-1:0]),
        .duty_i   (regs_q[RegDuty][C_CNT_WIDTH-1:0]),
        .pwm_o    (PWM_OUT)
    );
endmodule

// File: tb/tb_axil_pwm_slave.sv
// Scoreboard bench for axil_pwm_slave: random register traffic plus PWM waveform checks.
module tb_axil_pwm_slave;
    import axil_pwm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic pwm;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold_b   = 1'b0;

    logic [1:0]  bq[$];
    logic [31:0] rq[$];
    logic [31:0] model [4];
    bit          trace[$];

    axil_pwm_if #(.AddrWidth(4), .DataWidth(32)) bus ();

    axil_pwm_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .C_CNT_WIDTH        (32)
    ) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .s_axi   (bus.slave),
        .PWM_OUT (pwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_val & ~m) | (nw & m);
    endfunction

    // Random response back-pressure.
    initial begin
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.bready = !hold_b && ($urandom_range(0, 3) != 0);
            bus.rready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations whenever a response handshake is presented.
    initial begin
        logic [31:0] held;
        bit          hv;
        hv = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 1'b0;
            end else begin
                if (bus.bvalid && bus.bready) begin
                    if (bq.size() == 0) chk("unexpected_b", 32'd1, 32'd0);
                    else chk("bresp", 32'(bus.bresp), 32'(bq.pop_front()));
                end
                if (bus.rvalid) begin
                    if (hv) chk("rdata_stable", bus.rdata, held);
                    if (bus.rready) begin
                        if (rq.size() == 0) chk("unexpected_r", 32'd1, 32'd0);
                        else chk("rdata", bus.rdata, rq.pop_front());
                        chk("rresp", 32'(bus.rresp), 32'(RESP_OKAY));
                        hv = 1'b0;
                    end else begin
                        held = bus.rdata;
                        hv = 1'b1;
                    end
                end
            end
        end
    end

    task automatic aw_issue(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int t;
        t = 0;
        bq.push_back(RESP_OKAY);
        bus.awaddr = addr;
        bus.wdata = data;
        bus.wstrb = strb;
        bus.awvalid = 1'b1;
        bus.wvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.awready && bus.wready) && t < 100);
        if (t >= 100) chk("aw_timeout", 32'd1, 32'd0);
        @(posedge clk);
        model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
    endtask

    task automatic wait_b();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.bvalid && bus.bready) && t < 100);
        if (t >= 100) chk("b_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        aw_issue(addr, data, strb);
        wait_b();
    endtask

    task automatic axi_read(input logic [3:0] addr);
        int t;
        t = 0;
        rq.push_back(model[addr[3:2]]);
        bus.araddr = addr;
        bus.arvalid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.arready && t < 100);
        if (t >= 100) chk("ar_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.rvalid && bus.rready) && t < 100);
        if (t >= 100) chk("r_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n);
        trace.delete();
        repeat (n) begin
            @(negedge clk);
            trace.push_back(pwm);
        end
    endtask

    // Steady-state waveform: after the first rising edge, each period is h highs then lows.
    task automatic check_pattern(input string name, input int period, input int duty);
        int h, errs, start;
        h = (period == 0) ? 0 : ((duty < period) ? duty : period);
        errs = 0;
        start = -1;
        if (h == 0 || h == period) begin
            foreach (trace[j]) if (trace[j] != (h != 0)) errs++;
        end else begin
            for (int j = 1; j < trace.size(); j++) begin
                if (start < 0 && !trace[j-1] && trace[j]) start = j;
            end
            if (start < 0) errs = 1;
            else for (int j = start; j < trace.size(); j++)
                if (trace[j] != (((j - start) % period) < h)) errs++;
        end
        chk(name, 32'(errs), 32'd0);
    endtask

    task automatic pwm_config(input int period, input int duty);
        axi_write(OFS_CTRL, 32'd0, 4'hF);
        axi_write(OFS_PERIOD, 32'(period), 4'hF);
        axi_write(OFS_DUTY, 32'(duty), 4'hF);
        axi_write(OFS_CTRL, 32'd1, 4'hF);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, t;
        bit prev;
        logic [31:0] y;
        rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_pwm", 32'(pwm), 32'd0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        axi_write(OFS_SCRATCH, 32'h11223344, 4'hF);
        axi_write(OFS_SCRATCH, 32'hAABBCCDD, 4'b0010);
        chk("strobe_model", model[3], 32'h1122CC44);
        axi_read(OFS_SCRATCH);

        repeat (40) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom_range(0, 15)));
            else
                axi_read(4'($urandom_range(0, 3) * 4));
        end

        // Read and write of the same register accepted on the same edge.
        fork
            axi_write(OFS_SCRATCH, $urandom, 4'hF);
            axi_read(OFS_SCRATCH);
        join
        axi_read(OFS_SCRATCH);

        // Write response back-pressure blocks the next write.
        hold_b = 1'b1;
        @(posedge clk);
        #2;
        aw_issue(OFS_SCRATCH, 32'hCAFE0001, 4'hF);
        y = 32'h5A5A0002;
        bq.push_back(RESP_OKAY);
        bus.awaddr = OFS_SCRATCH; bus.wdata = y; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
            chk("aw_blocked", 32'(bus.awready), 32'd0);
        end
        hold_b = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.awready && t < 100);
        if (t >= 100) chk("aw2_timeout", 32'd1, 32'd0);
        @(posedge clk);
        model[3] = y;
        #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b();
        axi_read(OFS_SCRATCH);

        pwm_config(10, 3);
        collect(40);
        check_pattern("pwm_10_3", 10, 3);

        // Mid-period duty change only takes effect from the next period.
        prev = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (!prev && pwm) break;
            prev = pwm;
        end while (t < 100);
        if (t >= 100) chk("pwm_rise_timeout", 32'd1, 32'd0);
        fork
            collect(40);
            axi_write(OFS_DUTY, 32'd7, 4'hF);
        join
        errs = 0;
        foreach (trace[j]) begin
            int p;
            p = j + 1;
            if (trace[j] != ((p < 10) ? (p < 3) : (((p - 10) % 10) < 7))) errs++;
        end
        chk("pwm_duty_update", 32'(errs), 32'd0);

        repeat (4) begin
            int p, d;
            p = $urandom_range(1, 12);
            d = $urandom_range(0, 14);
            pwm_config(p, d);
            collect(3 * p + 6);
            check_pattern("pwm_random", p, d);
        end

        pwm_config(10, 0);
        collect(30);
        check_pattern("pwm_duty0", 10, 0);
        pwm_config(10, 12);
        collect(30);
        check_pattern("pwm_duty_over", 10, 12);
        axi_write(OFS_PERIOD, 32'd0, 4'hF);
        repeat (14) @(posedge clk);
        collect(20);
        check_pattern("pwm_period0", 0, 12);

        pwm_config(10, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge clk);
        chk("rst_pwm_after", 32'(pwm), 32'd0);
        collect(15);
        check_pattern("pwm_after_reset", 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        repeat (4) @(posedge clk);
        chk("bq_empty", 32'(bq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
